td4_run_controller: RTL

- Run/debug sequencer for the 4-bit TD4 CPU core.
- Owns the 16x8 program memory and answers CPU fetches from it.
- Drives CPU reset (cpu_rst) and a per-cycle clock enable (cpu_ce); a thin CPU wrapper gates every register update with cpu_ce.
- Provides load, run, halt, single-step, restart, an address breakpoint and a cycle-budget timeout.

---
 rtl/td4_pkg.sv | 22 ++
 rtl/td4_run_controller_if.sv | 35 +++
 rtl/td4_prog_mem.sv | 28 ++
 rtl/td4_run_controller.sv | 138 +++++++++++++
 4 files changed

// File: rtl/td4_pkg.sv
// Shared encodings and widths for the TD4 run controller and its program memory.
package td4_pkg;

    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned INSTR_W   = 8;
    localparam int unsigned MEM_DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        CPU_RST = 2'd0,
        IDLE    = 2'd1,
        RUN     = 2'd2,
        STEP    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CMD_RUN     = 2'd0,
        CMD_HALT    = 2'd1,
        CMD_STEP    = 2'd2,
        CMD_RESTART = 2'd3
    } cmd_t;

endpackage

// File: rtl/td4_run_controller_if.sv
// Host/debugger and CPU-side signals of the TD4 run controller.
interface td4_run_controller_if #(
    parameter int unsigned CNT_W = 16
);
    import td4_pkg::*;

    logic               load_valid;
    logic               load_ready;
    logic [ADDR_W-1:0]  load_addr;
    logic [INSTR_W-1:0] load_data;
    logic               cmd_valid;
    logic [1:0]         cmd;
    logic               bp_en;
    logic [ADDR_W-1:0]  bp_addr;
    logic [ADDR_W-1:0]  cpu_address;
    logic [INSTR_W-1:0] cpu_instr;
    logic               cpu_rst;
    logic               cpu_ce;
    logic               halted;
    logic               bp_hit;
    logic               timeout;
    logic [CNT_W-1:0]   cycle_count;
    logic [1:0]         state_o;

    modport slave (
        input  load_valid, load_addr, load_data, cmd_valid, cmd, bp_en, bp_addr, cpu_address,
        output load_ready, cpu_instr, cpu_rst, cpu_ce, halted, bp_hit, timeout, cycle_count, state_o
    );

    modport master (
        output load_valid, load_addr, load_data, cmd_valid, cmd, bp_en, bp_addr, cpu_address,
        input  load_ready, cpu_instr, cpu_rst, cpu_ce, halted, bp_hit, timeout, cycle_count, state_o
    );

endinterface

// File: rtl/td4_prog_mem.sv
// 16x8 program memory: synchronous write, asynchronous read, cleared by reset.
module td4_prog_mem
    import td4_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(MEM_DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/td4_run_controller.sv
// Run/debug sequencer for the TD4 core: CPU reset, clock enable, breakpoint,
// single-step and cycle budget, plus the program memory that feeds fetches.
module td4_run_controller
    import td4_pkg::*;
#(
    parameter int unsigned RST_CYCLES = 2,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned MAX_CYCLES = 0
) (
    input  logic                clk,
    input  logic                reset,
    td4_run_controller_if.slave bus
);

    localparam int unsigned     RCNT_W  = $clog2(RST_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_SAT = '1;
    localparam logic [CNT_W-1:0] BUDGET  = CNT_W'(MAX_CYCLES);

    state_t             state, state_nxt;
    logic [RCNT_W-1:0]  rst_cnt, rst_cnt_nxt;
    logic [CNT_W-1:0]   cycle_count, count_nxt;
    logic               bp_hit, bp_hit_nxt;
    logic               timeout, timeout_nxt;
    logic               bp_skip, bp_skip_nxt;
    logic               ce;

    logic cmd_run, cmd_halt, cmd_step, cmd_restart, bp_match;

    assign cmd_run     = bus.cmd_valid && (bus.cmd == CMD_RUN);
    assign cmd_halt    = bus.cmd_valid && (bus.cmd == CMD_HALT);
    assign cmd_step    = bus.cmd_valid && (bus.cmd == CMD_STEP);
    assign cmd_restart = bus.cmd_valid && (bus.cmd == CMD_RESTART);
    assign bp_match    = bus.bp_en && (bus.cpu_address == bus.bp_addr) && !bp_skip;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= CPU_RST;
            rst_cnt     <= RCNT_W'(RST_CYCLES);
            cycle_count <= '0;
            bp_hit      <= 1'b0;
            timeout     <= 1'b0;
            bp_skip     <= 1'b0;
        end else begin
            state       <= state_nxt;
            rst_cnt     <= rst_cnt_nxt;
            cycle_count <= count_nxt;
            bp_hit      <= bp_hit_nxt;
            timeout     <= timeout_nxt;
            bp_skip     <= bp_skip_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        rst_cnt_nxt = rst_cnt;
        count_nxt   = cycle_count;
        bp_hit_nxt  = bp_hit;
        timeout_nxt = timeout;
        bp_skip_nxt = bp_skip;
        ce          = 1'b0;

        if (cmd_restart && (state != CPU_RST)) begin
            state_nxt   = CPU_RST;
            rst_cnt_nxt = RCNT_W'(RST_CYCLES);
            count_nxt   = '0;
            bp_hit_nxt  = 1'b0;
            timeout_nxt = 1'b0;
        end else begin
            case (state)
                CPU_RST: begin
                    rst_cnt_nxt = rst_cnt - RCNT_W'(1);
                    if (rst_cnt == RCNT_W'(1)) begin
                        state_nxt = IDLE;
                    end
                end
                IDLE: begin
                    if (cmd_run && !timeout) begin
                        state_nxt   = RUN;
                        bp_skip_nxt = 1'b1;
                        bp_hit_nxt  = 1'b0;
                    end else if (cmd_step) begin
                        state_nxt   = STEP;
                        bp_skip_nxt = 1'b1;
                        bp_hit_nxt  = 1'b0;
                    end
                end
                RUN: begin
                    // HALT outranks a breakpoint in the same cycle and leaves bp_hit alone
                    if (cmd_halt) begin
                        state_nxt = IDLE;
                    end else if (bp_match) begin
                        state_nxt  = IDLE;
                        bp_hit_nxt = 1'b1;
                    end else begin
                        ce = 1'b1;
                    end
                end
                STEP: begin
                    ce        = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = CPU_RST;
            endcase

            // An executed cycle releases the breakpoint skip and advances the budget
            if (ce) begin
                bp_skip_nxt = 1'b0;
                if (cycle_count != CNT_SAT) begin
                    count_nxt = cycle_count + CNT_W'(1);
                    if ((MAX_CYCLES != 0) && (count_nxt == BUDGET)) begin
                        timeout_nxt = 1'b1;
                        state_nxt   = IDLE;
                    end
                end
            end
        end
    end

    td4_prog_mem u_prog_mem (
        .clk   (clk),
        .reset (reset),
        .we    ((state == IDLE) && bus.load_valid),
        .waddr (bus.load_addr),
        .wdata (bus.load_data),
        .raddr (bus.cpu_address),
        .rdata (bus.cpu_instr)
    );

    assign bus.cpu_ce      = ce && !reset;
    assign bus.cpu_rst     = (state == CPU_RST);
    assign bus.load_ready  = (state == IDLE);
    assign bus.halted      = (state == IDLE);
    assign bus.bp_hit      = bp_hit;
    assign bus.timeout     = timeout;
    assign bus.cycle_count = cycle_count;
    assign bus.state_o     = state;

endmodule
